// File: rtl/coin_pkg.sv
// Shared definitions for the coin input conditioner: channel count,
// channel indices, output FSM states and a priority-select helper.
package coin_pkg;

   localparam int unsigned NUM_COIN = 3;

   localparam int unsigned COIN_1Y  = 0;
   localparam int unsigned COIN_5Y  = 1;
   localparam int unsigned COIN_10Y = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } coin_state_e;

   // One-hot of the lowest set bit; all-zero when nothing is set.
   function automatic logic [NUM_COIN-1:0] lowest_onehot(input logic [NUM_COIN-1:0] v);
      logic [NUM_COIN-1:0] r;
      logic                found;
      r     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_COIN; i++) begin
         if (v[i] && !found) begin
            r[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/coin_debounce_ch.sv
// One coin channel: 2-flop synchroniser, debounce counter, debounced
// level and a single-cycle pulse when the debounced level rises.
module coin_debounce_ch #(
   parameter int unsigned DEB_CYCLES = 50000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic rise_o
);

   logic             s1_q, s2_q;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept the synchronised level once it has disagreed with db for DEB_CYCLES cycles.
   always_comb begin
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            db_d   = s2_q;
            rise_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser, counter, debounced level and rise pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= raw_i;
         s2_q   <= s1_q;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces the three coin switches and serialises accepted coins into
// one-hot pulses with a guaranteed gap, queueing one coin per channel.
module coin_input_conditioner
   import coin_pkg::*;
#(
   parameter int unsigned DEB_CYCLES   = 50000,
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COIN-1:0] coin_raw,
   input  logic                clr_ovf,
   output logic [NUM_COIN-1:0] coin_out,
   output logic                busy,
   output logic [NUM_COIN-1:0] overflow
);

   logic [NUM_COIN-1:0] rise;
   logic [NUM_COIN-1:0] req;
   logic [NUM_COIN-1:0] sel;

   coin_state_e         state_q, state_d;
   logic [CNT_W-1:0]    pcnt_q, pcnt_d;
   logic [NUM_COIN-1:0] coin_q, coin_d;
   logic [NUM_COIN-1:0] pend_q, pend_d;
   logic [NUM_COIN-1:0] ovf_q, ovf_d;

   for (genvar g = 0; g < NUM_COIN; g++) begin : g_ch
      coin_debounce_ch #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_deb (
         .clk    (clk),
         .reset  (reset),
         .raw_i  (coin_raw[g]),
         .rise_o (rise[g])
      );
   end

   // Output FSM: priority select in IDLE, timed pulse, then timed gap.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      coin_d  = coin_q;
      sel     = '0;
      req     = pend_q | rise;
      unique case (state_q)
         ST_IDLE: begin
            coin_d = '0;
            pcnt_d = '0;
            if (req != '0) begin
               sel     = lowest_onehot(req);
               coin_d  = sel;
               state_d = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (pcnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
               coin_d  = '0;
               pcnt_d  = '0;
               state_d = ST_GAP;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            // Leave one cycle early: the IDLE cycle that follows is the last
            // gap cycle, so back-to-back coins keep a PULSE+GAP period.
            coin_d = '0;
            if (pcnt_q == CNT_W'(GAP_CYCLES - 2)) begin
               pcnt_d  = '0;
               state_d = ST_IDLE;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         default: begin
            coin_d  = '0;
            pcnt_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Queue and loss tracking: unserved rises pend; a rise onto an occupied
   // slot is dropped and flagged. A served slot with a fresh rise stays full.
   always_comb begin
      pend_d = ((pend_q | rise) & ~sel) | (pend_q & rise & sel);
      ovf_d  = (clr_ovf ? '0 : ovf_q) | (pend_q & rise & ~sel);
   end

   // State, counter, output and queue registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pcnt_q  <= '0;
         coin_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         coin_q  <= coin_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign coin_out = coin_q;
   assign busy     = (state_q != ST_IDLE);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with a short debounce window.
module tb_coin_input_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] coin_raw;
   logic       clr_ovf;
   logic [2:0] coin_out;
   logic       busy;
   logic [2:0] overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   int         pulses [3];
   int         multi_hot = 0;
   logic [2:0] prev_out  = '0;
   int         p;

   coin_input_conditioner #(
      .DEB_CYCLES   (8),
      .PULSE_CYCLES (4),
      .GAP_CYCLES   (4),
      .CNT_W        (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .coin_raw (coin_raw),
      .clr_ovf  (clr_ovf),
      .coin_out (coin_out),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Count rising edges per output bit and any multi-hot output.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (coin_out[i] && !prev_out[i]) pulses[i] <= pulses[i] + 1;
      end
      if ($countones(coin_out) > 1) multi_hot <= multi_hot + 1;
      prev_out <= coin_out;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go(input int n);
      while (cyc < t0 + n) tick();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) pulses[i] = 0;
      reset    = 1'b1;
      coin_raw = 3'b000;
      clr_ovf  = 1'b0;
      tick(); tick(); tick();
      check("rst_coin_out", 32'(coin_out), 32'h0);
      check("rst_busy",     32'(busy),     32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      reset = 1'b0;
      tick();

      // Single coin on channel 0
      t0 = cyc;
      coin_raw = 3'b001;
      go(10); check("t1_before",  32'(coin_out), 32'h0);
      go(11); check("t1_start",   32'(coin_out), 32'h1);
              check("t1_busy",    32'(busy),     32'h1);
      go(14); check("t1_last",    32'(coin_out), 32'h1);
      go(15); check("t1_end",     32'(coin_out), 32'h0);
      go(20); coin_raw = 3'b000;
      go(50); check("t1_idle",    32'(busy),     32'h0);
              check("t1_count",   32'(pulses[0]), 32'd1);

      // Bouncing channel 1, then stable high
      t0 = cyc;
      p  = pulses[1];
      for (int k = 0; k < 10; k++) begin
         coin_raw[1] = (k % 2 == 0);
         go(3 * k + 3);
      end
      check("t2_no_bounce", 32'(pulses[1] - p), 32'd0);
      coin_raw[1] = 1'b1;
      go(40); check("t2_before", 32'(coin_out), 32'h0);
      go(41); check("t2_start",  32'(coin_out), 32'h2);
      go(45); check("t2_end",    32'(coin_out), 32'h0);
      go(70); check("t2_count",  32'(pulses[1] - p), 32'd1);
      coin_raw = 3'b000;
      go(100);

      // Simultaneous coins on all channels
      t0 = cyc;
      coin_raw = 3'b111;
      go(10); check("t3_before", 32'(coin_out), 32'h0);
      go(11); check("t3_ch0",    32'(coin_out), 32'h1);
      go(15); check("t3_gap0",   32'(coin_out), 32'h0);
      go(18); check("t3_gap0b",  32'(coin_out), 32'h0);
      go(19); check("t3_ch1",    32'(coin_out), 32'h2);
      go(27); check("t3_ch2",    32'(coin_out), 32'h4);
      go(31); check("t3_end",    32'(coin_out), 32'h0);
      coin_raw = 3'b000;
      go(50); check("t3_ovf",    32'(overflow), 32'h0);
      go(80);

      // Channel 2 starved by channels 0/1, then hit again while still queued
      t0 = cyc;
      coin_raw = 3'b111;
      go(8);  coin_raw[0] = 1'b0;
      go(11); check("t4_ch0a",    32'(coin_out), 32'h1);
      go(12); coin_raw[2] = 1'b0;
      go(16); coin_raw[0] = 1'b1;
      go(19); check("t4_ch1",     32'(coin_out), 32'h2);
      go(22); coin_raw[2] = 1'b1;
      go(27); check("t4_ch0b",    32'(coin_out), 32'h1);
      go(32); check("t4_ovf_pre", 32'(overflow), 32'h0);
      go(33); check("t4_ovf_set", 32'(overflow), 32'h4);
      go(35); check("t4_ch2",     32'(coin_out), 32'h4);
      go(40); clr_ovf = 1'b1;
      go(41); check("t4_ovf_clr", 32'(overflow), 32'h0);
      clr_ovf  = 1'b0;
      coin_raw = 3'b000;
      go(80); check("t4_idle",    32'(busy), 32'h0);

      // Reset during the second cycle of a pulse
      t0 = cyc;
      coin_raw = 3'b001;
      go(11); check("t5_start", 32'(coin_out), 32'h1);
      go(12); reset = 1'b1; coin_raw = 3'b000;
      go(13); check("t5_rst_out",  32'(coin_out), 32'h0);
              check("t5_rst_busy", 32'(busy),     32'h0);
      p = pulses[0];
      go(15); reset = 1'b0;
      go(50); check("t5_no_pulse", 32'(pulses[0] - p), 32'd0);
              check("t5_idle",     32'(busy), 32'h0);

      // Switch held high through reset release
      reset    = 1'b1;
      coin_raw = 3'b100;
      tick(); tick(); tick();
      reset = 1'b0;
      t0 = cyc;
      p  = pulses[2];
      go(10); check("t6_before", 32'(coin_out), 32'h0);
      go(11); check("t6_start",  32'(coin_out), 32'h4);
      go(14); check("t6_last",   32'(coin_out), 32'h4);
      go(15); check("t6_end",    32'(coin_out), 32'h0);
      go(40); check("t6_count",  32'(pulses[2] - p), 32'd1);
      coin_raw = 3'b000;
      go(60);

      check("onehot", 32'(multi_hot), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
